// File: rtl/regfile_pkg.sv
// Shared definitions for the register file write-back path: default sizes,
// the write-back entry payload and a cyclic index helper.
package regfile_pkg;

  localparam int unsigned DEF_NUM_SRC      = 8;
  localparam int unsigned DEF_NUM_WR_PORTS = 6;
  localparam int unsigned DEF_SRAM_INDEX   = 5;
  localparam int unsigned DEF_SRAM_WIDTH   = 32;

  typedef struct packed {
    logic [DEF_SRAM_INDEX-1:0] addr;
    logic [DEF_SRAM_WIDTH-1:0] data;
  } wb_entry_t;

  // Wraps an index that is known to be below 2*n back into [0, n).
  function automatic int unsigned wrap_idx(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/rr_multi_grant.sv
// Combinational round-robin allocator: grants up to P requesters per cycle,
// scanning cyclically from ptr_i; the k-th grant in scan order lands on slot k.
module rr_multi_grant
  import regfile_pkg::*;
#(
  parameter int unsigned N  = DEF_NUM_SRC,
  parameter int unsigned P  = DEF_NUM_WR_PORTS,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] gnt_idx_c [P],
  output logic [P-1:0]  gnt_vld_c,
  output logic [N-1:0]  gnt_mask_c,
  output logic [IW-1:0] next_ptr_c
);

  int unsigned cnt;
  int unsigned idx;

  always_comb begin
    gnt_vld_c  = '0;
    gnt_mask_c = '0;
    next_ptr_c = ptr_i;
    cnt        = 0;
    idx        = 0;
    for (int unsigned k = 0; k < P; k++) begin
      gnt_idx_c[k] = '0;
    end
    for (int unsigned k = 0; k < N; k++) begin
      idx = wrap_idx(32'(ptr_i) + k, N);
      if (req_i[idx] && (cnt < P)) begin
        gnt_idx_c[cnt]  = IW'(idx);
        gnt_vld_c[cnt]  = 1'b1;
        gnt_mask_c[idx] = 1'b1;
        next_ptr_c      = IW'(wrap_idx(idx + 1, N));
        cnt             = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-side front end of the banked register file: per-source holding
// registers feeding registered write ports. Optional REGFILE_WB_COLLISION_CHECK_EN.
module regfile_wb_scheduler
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_SRC      = DEF_NUM_SRC,
  parameter int unsigned NUM_WR_PORTS = DEF_NUM_WR_PORTS,
  parameter int unsigned SRAM_INDEX   = DEF_SRAM_INDEX,
  parameter int unsigned SRAM_WIDTH   = DEF_SRAM_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_SRC-1:0]                 src_valid_i,
  output logic [NUM_SRC-1:0]                 src_ready_o,
  input  logic [NUM_SRC*SRAM_INDEX-1:0]      src_addr_i,
  input  logic [NUM_SRC*SRAM_WIDTH-1:0]      src_data_i,
  output logic [NUM_WR_PORTS-1:0]            we_o,
  output logic [NUM_WR_PORTS*SRAM_INDEX-1:0] addrwr_o,
  output logic [NUM_WR_PORTS*SRAM_WIDTH-1:0] datawr_o,
  output logic [$clog2(NUM_SRC+1)-1:0]       pending_cnt_o,
  output logic                               collision_o
);

  localparam int unsigned IW = $clog2(NUM_SRC);
  localparam int unsigned CW = $clog2(NUM_SRC+1);

  logic [NUM_SRC-1:0]                 full_q, full_d;
  logic [SRAM_INDEX-1:0]              addr_q [NUM_SRC];
  logic [SRAM_INDEX-1:0]              addr_d [NUM_SRC];
  logic [SRAM_WIDTH-1:0]              data_q [NUM_SRC];
  logic [SRAM_WIDTH-1:0]              data_d [NUM_SRC];
  logic [IW-1:0]                      rr_ptr_q, rr_ptr_d;
  logic [NUM_WR_PORTS-1:0]            we_q, we_d;
  logic [NUM_WR_PORTS*SRAM_INDEX-1:0] addrwr_q, addrwr_d;
  logic [NUM_WR_PORTS*SRAM_WIDTH-1:0] datawr_q, datawr_d;
  logic [CW-1:0]                      pending_q, pending_d;

  logic [IW-1:0]           gnt_idx_c [NUM_WR_PORTS];
  logic [NUM_WR_PORTS-1:0] gnt_vld_c;
  logic [NUM_SRC-1:0]      gnt_mask_c;
  logic [IW-1:0]           next_ptr_c;
  logic [NUM_SRC-1:0]      accept_c;
  logic [SRAM_INDEX-1:0]   gaddr_c [NUM_WR_PORTS];

  rr_multi_grant #(
    .N  (NUM_SRC),
    .P  (NUM_WR_PORTS),
    .IW (IW)
  ) u_grant (
    .req_i      (full_q),
    .ptr_i      (rr_ptr_q),
    .gnt_idx_c  (gnt_idx_c),
    .gnt_vld_c  (gnt_vld_c),
    .gnt_mask_c (gnt_mask_c),
    .next_ptr_c (next_ptr_c)
  );

  // A slot being drained this cycle can be refilled in the same cycle.
  assign src_ready_o = ~full_q | gnt_mask_c;
  assign accept_c    = src_valid_i & src_ready_o;

  always_comb begin
    full_d    = (full_q & ~gnt_mask_c) | accept_c;
    pending_d = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      addr_d[i] = addr_q[i];
      data_d[i] = data_q[i];
      if (accept_c[i]) begin
        addr_d[i] = src_addr_i[i*SRAM_INDEX +: SRAM_INDEX];
        data_d[i] = src_data_i[i*SRAM_WIDTH +: SRAM_WIDTH];
      end
      pending_d = pending_d + CW'(full_d[i]);
    end
    rr_ptr_d = next_ptr_c;
    we_d     = gnt_vld_c;
    addrwr_d = addrwr_q;
    datawr_d = datawr_q;
    for (int unsigned k = 0; k < NUM_WR_PORTS; k++) begin
      gaddr_c[k] = addr_q[gnt_idx_c[k]];
      if (gnt_vld_c[k]) begin
        addrwr_d[k*SRAM_INDEX +: SRAM_INDEX] = gaddr_c[k];
        datawr_d[k*SRAM_WIDTH +: SRAM_WIDTH] = data_q[gnt_idx_c[k]];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q    <= '0;
      rr_ptr_q  <= '0;
      we_q      <= '0;
      addrwr_q  <= '0;
      datawr_q  <= '0;
      pending_q <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      full_q    <= full_d;
      rr_ptr_q  <= rr_ptr_d;
      we_q      <= we_d;
      addrwr_q  <= addrwr_d;
      datawr_q  <= datawr_d;
      pending_q <= pending_d;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign we_o          = we_q;
  assign addrwr_o      = addrwr_q;
  assign datawr_o      = datawr_q;
  assign pending_cnt_o = pending_q;

`ifdef REGFILE_WB_COLLISION_CHECK_EN
  logic collision_q, collision_d, coll_c;

  // Pairwise address compare across this cycle's grants; sticky until reset.
  always_comb begin
    coll_c = 1'b0;
    for (int unsigned p = 0; p < NUM_WR_PORTS; p++) begin
      for (int unsigned q = p + 1; q < NUM_WR_PORTS; q++) begin
        if (gnt_vld_c[p] && gnt_vld_c[q] && (gaddr_c[p] == gaddr_c[q])) begin
          coll_c = 1'b1;
        end
      end
    end
    collision_d = collision_q | coll_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= collision_d;
    end
  end

  assign collision_o = collision_q;
`else
  assign collision_o = 1'b0;
`endif

endmodule
